// File: rtl/serial_mag_comp_if.sv
// Digit-stream and result bundle for serial_mag_comp.
// Optional seed ports eq_in/gt_in exist only when CASCADE_IN_EN is defined.
interface serial_mag_comp_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] a_dig;
  logic [1:0] b_dig;
  logic       busy;
  logic       done;
  logic       eq;
  logic       gt;
  logic       lt;
`ifdef CASCADE_IN_EN
  logic       eq_in;
  logic       gt_in;

  modport master (
    output start, in_valid, a_dig, b_dig, eq_in, gt_in,
    input  in_ready, busy, done, eq, gt, lt
  );
  modport slave (
    input  start, in_valid, a_dig, b_dig, eq_in, gt_in,
    output in_ready, busy, done, eq, gt, lt
  );
`else
  modport master (
    output start, in_valid, a_dig, b_dig,
    input  in_ready, busy, done, eq, gt, lt
  );
  modport slave (
    input  start, in_valid, a_dig, b_dig,
    output in_ready, busy, done, eq, gt, lt
  );
`endif
endinterface

// File: rtl/serial_mag_comp.sv
// Bit-serial magnitude comparator, two bits per cycle, MSB digit first.
// Optional feature macro: CASCADE_IN_EN (seed EQ/GT from cmp.eq_in/cmp.gt_in).
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_mag_comp_if.slave    cmp,
  output logic [1:0]          fsm_state
);
  // Handshake: a digit pair transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready depends on FSM state only.
  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            st_eq, st_gt;
  logic            eq_nx, gt_nx;
  logic            seed_eq, seed_gt;
  logic            res_eq, res_gt, res_lt;
  logic            accept, last, load;

`ifdef CASCADE_IN_EN
  assign seed_eq = cmp.eq_in;
  assign seed_gt = cmp.gt_in;
`else
  assign seed_eq = 1'b1;
  assign seed_gt = 1'b0;
`endif

  assign accept = (state == RUN) && cmp.in_valid;
  assign last   = (cnt == CW'(DIGITS - 1));
  assign load   = ((state == IDLE) || (state == DONE)) && cmp.start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmp.start) state_nx = RUN;
      RUN:     if (accept && last) state_nx = DONE;
      DONE:    state_nx = cmp.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmp.busy     = (state == RUN);
    cmp.in_ready = (state == RUN);
    cmp.done     = (state == DONE);
  end

  // Once a higher digit has decided (st_eq=0), lower digits cannot change it.
  always_comb begin
    eq_nx = st_eq;
    gt_nx = st_gt;
    if (st_eq) begin
      if (cmp.a_dig > cmp.b_dig) begin
        eq_nx = 1'b0;
        gt_nx = 1'b1;
      end else if (cmp.a_dig < cmp.b_dig) begin
        eq_nx = 1'b0;
        gt_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_eq  <= 1'b1;
      st_gt  <= 1'b0;
      cnt    <= '0;
      res_eq <= 1'b0;
      res_gt <= 1'b0;
      res_lt <= 1'b0;
    end else if (load) begin
      st_eq <= seed_eq;
      st_gt <= seed_gt;
      cnt   <= '0;
    end else if (accept) begin
      st_eq <= eq_nx;
      st_gt <= gt_nx;
      if (last) begin
        cnt    <= '0;
        res_eq <= eq_nx;
        res_gt <= gt_nx;
        res_lt <= !eq_nx && !gt_nx;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign cmp.eq    = res_eq;
  assign cmp.gt    = res_gt;
  assign cmp.lt    = res_lt;
  assign fsm_state = state;
endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed + random bench for serial_mag_comp; results checked through an
// expected queue popped on each done pulse.
module tb_serial_mag_comp;
  localparam int W   = 8;
  localparam int DIG = W / 2;

  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;
  int         cyc;
  int         n_cmp;
  int         n_err;

  logic [2:0] exp_q[$];
  int         cyc_q[$];

  serial_mag_comp_if cmp();

  serial_mag_comp #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmp       (cmp),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [2:0] e;
    int         c;
    if (!rst && cmp.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_done: observed done=1 expected no pending result");
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("result_eq_gt_lt", {29'd0, cmp.eq, cmp.gt, cmp.lt}, {29'd0, e});
        check("done_cycle", cyc, c);
      end
    end
  end

  // driver: start, then stream DIG digits; stall_len idle cycles before digit 2
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input int stall_len,
                         input bit start_in_run, input bit chk_zero,
                         input logic seed_eq, input logic seed_gt);
    logic [2:0] e;
    if (!seed_eq) e = {1'b0, seed_gt, !seed_gt};
    else          e = {a == b, a > b, a < b};
    cmp.start = 1'b1;
`ifdef CASCADE_IN_EN
    cmp.eq_in = seed_eq;
    cmp.gt_in = seed_gt;
`endif
    @(posedge clk); #1;
    cmp.start = 1'b0;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + DIG + stall_len);
    check("run_busy", {31'd0, cmp.busy}, 32'd1);
    check("run_in_ready", {31'd0, cmp.in_ready}, 32'd1);
    if (chk_zero) check("outputs_cleared", {29'd0, cmp.eq, cmp.gt, cmp.lt}, 32'd0);
    for (int d = 0; d < DIG; d++) begin
      if (d == 2 && stall_len > 0) begin
        cmp.in_valid = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          check("stall_state_run", {30'd0, fsm_state}, 32'd1);
          check("stall_no_done", {31'd0, cmp.done}, 32'd0);
        end
      end
      cmp.in_valid = 1'b1;
      cmp.a_dig    = a[7-2*d -: 2];
      cmp.b_dig    = b[7-2*d -: 2];
      cmp.start    = start_in_run && (d == 1);
      @(posedge clk); #1;
    end
    cmp.in_valid = 1'b0;
    cmp.start    = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    cmp.start    = 1'b0;
    cmp.in_valid = 1'b0;
    cmp.a_dig    = 2'd0;
    cmp.b_dig    = 2'd0;
`ifdef CASCADE_IN_EN
    cmp.eq_in    = 1'b1;
    cmp.gt_in    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, cmp.busy}, 32'd0);
    check("rst_in_ready", {31'd0, cmp.in_ready}, 32'd0);
    check("rst_done", {31'd0, cmp.done}, 32'd0);
    check("rst_outputs", {29'd0, cmp.eq, cmp.gt, cmp.lt}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    rst = 1'b0;

    // in_valid outside RUN is ignored
    cmp.in_valid = 1'b1;
    cmp.a_dig    = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("idle_in_ready", {31'd0, cmp.in_ready}, 32'd0);
    check("idle_state", {30'd0, fsm_state}, 32'd0);
    cmp.in_valid = 1'b0;

    run_cmp(8'hA5, 8'hA5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("done_in_done_cycle", {31'd0, cmp.done}, 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, cmp.done}, 32'd0);
    check("back_to_idle", {30'd0, fsm_state}, 32'd0);
    check("result_held", {29'd0, cmp.eq, cmp.gt, cmp.lt}, 32'd4);

    run_cmp(8'hA6, 8'hA5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    run_cmp(8'h3F, 8'h40, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    run_cmp(8'hC0, 8'h80, 3, 1'b0, 1'b0, 1'b1, 1'b0);

    // back-to-back restarts from DONE, start during RUN ignored
    run_cmp(8'h12, 8'h34, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cmp(8'h34, 8'h12, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_cmp(8'h77, 8'h77, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;

    // abort after two accepted digits
    cmp.start = 1'b1;
    @(posedge clk); #1;
    cmp.start    = 1'b0;
    cmp.in_valid = 1'b1;
    cmp.a_dig    = 2'd3;
    cmp.b_dig    = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst          = 1'b0;
    cmp.in_valid = 1'b0;
    check("abort_state", {30'd0, fsm_state}, 32'd0);
    check("abort_busy", {31'd0, cmp.busy}, 32'd0);
    check("abort_outputs", {29'd0, cmp.eq, cmp.gt, cmp.lt}, 32'd0);
    run_cmp(8'h12, 8'h12, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = (i % 2 == 0) ? ra ^ 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      run_cmp(ra, rb, $urandom_range(0, 2), 1'b0, 1'b0, 1'b1, 1'b0);
    end

`ifdef CASCADE_IN_EN
    @(posedge clk); #1;
    run_cmp(8'h00, 8'hFF, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cmp(8'h00, 8'hFF, 0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // drain scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
